// File: rtl/gate_model_bist_if.sv
// rtl/gate_model_bist_if.sv - control and gate-model bundle for the gate-model BIST harness
//
// Groups the lab-control handshake (start/abort/num_patterns/exp_sig in,
// busy/done/pass/signature/pat_count out) and the gate-model stimulus and
// response (dut_in out, dut_out in).
//   master : lab control plus gate model (drives start, abort, num_patterns, exp_sig, dut_out)
//   slave  : the BIST harness (drives dut_in, busy, done, pass, signature, pat_count)
interface gate_model_bist_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_patterns;
    logic [OUT_W-1:0] exp_sig;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;
    logic [CNT_W-1:0] pat_count;

    modport master (
        output start, abort, num_patterns, exp_sig, dut_out,
        input  dut_in, busy, done, pass, signature, pat_count
    );

    modport slave (
        input  start, abort, num_patterns, exp_sig, dut_out,
        output dut_in, busy, done, pass, signature, pat_count
    );
endinterface

// File: rtl/gate_model_bist.sv
// rtl/gate_model_bist.sv - LFSR/MISR built-in self-test harness for a combinational gate model
//
// An LFSR drives the gate-model inputs. Each pattern is held for SETTLE
// edges, and then the response is folded into a MISR. After num_patterns
// captures, the MISR signature is compared against exp_sig.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gate_model_bist_if.slave (control handshake plus gate-model stimulus/response)
module gate_model_bist #(
    parameter int             IN_W   = 20,
    parameter int             OUT_W  = 10,
    parameter int             CNT_W  = 16,
    parameter logic [IN_W-1:0]  TAPS  = 20'h90000,
    parameter logic [OUT_W-1:0] MTAPS = 10'h240,
    parameter logic [IN_W-1:0]  SEED  = IN_W'(1),
    parameter int             SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_model_bist_if.slave  bus
);

    // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
    localparam logic [IN_W-1:0] SEED_V = (SEED == '0) ? IN_W'(1) : SEED;
    localparam int              SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [IN_W-1:0]  lfsr_q,   lfsr_d;
    logic [OUT_W-1:0] misr_q,   misr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] n_q,      n_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;
    logic [CNT_W-1:0] cnt_inc;

    assign lfsr_next = {lfsr_q[IN_W-2:0], ^(lfsr_q & TAPS)};
    assign misr_next = {misr_q[OUT_W-2:0], ^(misr_q & MTAPS)} ^ bus.dut_out;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        misr_d   = misr_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // start wins over abort here; abort means nothing outside RUN.
                if (bus.start) begin
                    lfsr_d   = SEED_V;
                    misr_d   = '0;
                    cnt_d    = '0;
                    settle_d = '0;
                    n_d      = bus.num_patterns;
                    done_d   = 1'b0;
                    if (bus.num_patterns == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end else if (state_q == S_DONE) begin
                    // done trails entry into DONE by one edge; this is the
                    // compare cycle after the last MISR update.
                    done_d = 1'b1;
                end
            end

            S_RUN: begin
                if (bus.abort) begin
                    // Partial signature and count are left visible.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (settle_q != SETTLE_LAST) begin
                    settle_d = settle_q + SW'(1);
                end else begin
                    misr_d   = misr_next;
                    lfsr_d   = lfsr_next;
                    cnt_d    = cnt_inc;
                    settle_d = '0;
                    if (cnt_inc == n_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED_V;
            misr_q   <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            misr_q   <= misr_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.dut_in    = lfsr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = misr_q;
    assign bus.pat_count = cnt_q;
    // exp_sig may change while in DONE, so pass follows it combinationally.
    assign bus.pass      = done_q && (misr_q == bus.exp_sig);

endmodule

// File: tb/tb_gate_model_bist.sv
// tb/tb_gate_model_bist.sv - directed self-checking bench for gate_model_bist
module tb_gate_model_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    logic [3:0] lfsr_seq [0:14];

    gate_model_bist_if #(.IN_W(4), .OUT_W(4), .CNT_W(16)) if_a ();
    gate_model_bist_if #(.IN_W(4), .OUT_W(4), .CNT_W(16)) if_b ();

    // Loopback gate models: the response equals the stimulus.
    assign if_a.dut_out = if_a.dut_in;
    assign if_b.dut_out = if_b.dut_in;

    gate_model_bist #(.IN_W(4), .OUT_W(4), .CNT_W(16), .TAPS(4'hC), .MTAPS(4'hC),
                      .SEED(4'h1), .SETTLE(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

    gate_model_bist #(.IN_W(4), .OUT_W(4), .CNT_W(16), .TAPS(4'hC), .MTAPS(4'hC),
                      .SEED(4'h1), .SETTLE(3))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [15:0] n, input logic [3:0] e);
        if_a.num_patterns = n;
        if_a.exp_sig      = e;
        if_a.start        = 1'b1;
        tick();
        if_a.start        = 1'b0;
    endtask

    task automatic start_b(input logic [15:0] n, input logic [3:0] e);
        if_b.num_patterns = n;
        if_b.exp_sig      = e;
        if_b.start        = 1'b1;
        tick();
        if_b.start        = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (if_a.dut_in !== 4'h1) $display("FAIL reset_dut_in: got %h want 1", if_a.dut_in); else passes++;
        checks++; if (if_a.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if_a.busy); else passes++;
        checks++; if (if_a.done !== 1'b0) $display("FAIL reset_done: got %b want 0", if_a.done); else passes++;
        checks++; if (if_a.pass !== 1'b0) $display("FAIL reset_pass: got %b want 0", if_a.pass); else passes++;
        checks++; if (if_a.signature !== 4'h0) $display("FAIL reset_sig: got %h want 0", if_a.signature); else passes++;
        checks++; if (if_a.pat_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", if_a.pat_count); else passes++;
        checks++; if (if_b.dut_in !== 4'h1) $display("FAIL reset_b_dut_in: got %h want 1", if_b.dut_in); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lfsr_sequence;
        start_a(16'd15, 4'h0);
        checks++; if (if_a.busy !== 1'b1) $display("FAIL lfsr_busy: got %b want 1", if_a.busy); else passes++;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (if_a.dut_in !== lfsr_seq[i]) $display("FAIL lfsr_step%0d: got %h want %h", i, if_a.dut_in, lfsr_seq[i]);
            else passes++;
            checks++;
            if (if_a.done !== 1'b0) $display("FAIL lfsr_early_done%0d: got %b want 0", i, if_a.done);
            else passes++;
            tick();
        end
        checks++; if (if_a.dut_in !== 4'h1) $display("FAIL lfsr_wrap: got %h want 1", if_a.dut_in); else passes++;
        checks++; if (if_a.pat_count !== 16'd15) $display("FAIL lfsr_count: got %0d want 15", if_a.pat_count); else passes++;
        checks++; if (if_a.done !== 1'b0) $display("FAIL lfsr_done15: got %b want 0", if_a.done); else passes++;
        tick();
        checks++; if (if_a.done !== 1'b1) $display("FAIL lfsr_done16: got %b want 1", if_a.done); else passes++;
        checks++; if (if_a.busy !== 1'b0) $display("FAIL lfsr_busy_end: got %b want 0", if_a.busy); else passes++;
    endtask

    task automatic test_loopback;
        logic [3:0] exp_s [0:2];
        exp_s[0] = 4'h1; exp_s[1] = 4'h0; exp_s[2] = 4'h4;
        start_a(16'd3, 4'h4);
        checks++; if (if_a.done !== 1'b0) $display("FAIL loop_done_clear: got %b want 0", if_a.done); else passes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_a.signature !== exp_s[i]) $display("FAIL loop_sig%0d: got %h want %h", i, if_a.signature, exp_s[i]);
            else passes++;
        end
        tick();
        checks++; if (if_a.done !== 1'b1) $display("FAIL loop_done: got %b want 1", if_a.done); else passes++;
        checks++; if (if_a.pass !== 1'b1) $display("FAIL loop_pass: got %b want 1", if_a.pass); else passes++;
        checks++; if (if_a.pat_count !== 16'd3) $display("FAIL loop_count: got %0d want 3", if_a.pat_count); else passes++;
        start_a(16'd3, 4'h5);
        tick(); tick(); tick(); tick();
        checks++; if (if_a.done !== 1'b1) $display("FAIL loop2_done: got %b want 1", if_a.done); else passes++;
        checks++; if (if_a.pass !== 1'b0) $display("FAIL loop2_pass: got %b want 0", if_a.pass); else passes++;
        checks++; if (if_a.signature !== 4'h4) $display("FAIL loop2_sig: got %h want 4", if_a.signature); else passes++;
    endtask

    task automatic test_zero_patterns;
        start_a(16'd0, 4'h0);
        checks++; if (if_a.busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", if_a.busy); else passes++;
        tick();
        checks++; if (if_a.done !== 1'b1) $display("FAIL zero_done: got %b want 1", if_a.done); else passes++;
        checks++; if (if_a.pass !== 1'b1) $display("FAIL zero_pass: got %b want 1", if_a.pass); else passes++;
        checks++; if (if_a.signature !== 4'h0) $display("FAIL zero_sig: got %h want 0", if_a.signature); else passes++;
        if_a.exp_sig = 4'h3;
        #1;
        checks++; if (if_a.pass !== 1'b0) $display("FAIL zero_pass_bad: got %b want 0", if_a.pass); else passes++;
    endtask

    task automatic test_settle;
        start_b(16'd4, 4'h0);
        for (int e = 0; e < 12; e++) begin
            checks++;
            if (if_b.dut_in !== lfsr_seq[e / 3]) $display("FAIL settle_hold%0d: got %h want %h", e, if_b.dut_in, lfsr_seq[e / 3]);
            else passes++;
            tick();
        end
        checks++; if (if_b.done !== 1'b0) $display("FAIL settle_done12: got %b want 0", if_b.done); else passes++;
        checks++; if (if_b.pat_count !== 16'd4) $display("FAIL settle_count: got %0d want 4", if_b.pat_count); else passes++;
        tick();
        checks++; if (if_b.done !== 1'b1) $display("FAIL settle_done13: got %b want 1", if_b.done); else passes++;
        checks++; if (if_b.signature !== 4'h0) $display("FAIL settle_sig: got %h want 0", if_b.signature); else passes++;
        checks++; if (if_b.pass !== 1'b1) $display("FAIL settle_pass: got %b want 1", if_b.pass); else passes++;
    endtask

    task automatic test_abort;
        start_a(16'd10, 4'h0);
        tick(); tick();
        if_a.abort = 1'b1;
        tick();
        if_a.abort = 1'b0;
        checks++; if (if_a.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", if_a.busy); else passes++;
        checks++; if (if_a.done !== 1'b0) $display("FAIL abort_done: got %b want 0", if_a.done); else passes++;
        checks++; if (if_a.pat_count !== 16'd2) $display("FAIL abort_count: got %0d want 2", if_a.pat_count); else passes++;
        checks++; if (if_a.signature !== 4'h0) $display("FAIL abort_sig: got %h want 0", if_a.signature); else passes++;
        tick();
        checks++; if (if_a.dut_in !== 4'h4) $display("FAIL abort_lfsr_hold: got %h want 4", if_a.dut_in); else passes++;
        start_a(16'd3, 4'h4);
        tick(); tick(); tick(); tick();
        checks++; if (if_a.done !== 1'b1) $display("FAIL abort_rerun_done: got %b want 1", if_a.done); else passes++;
        checks++; if (if_a.pass !== 1'b1) $display("FAIL abort_rerun_pass: got %b want 1", if_a.pass); else passes++;
        checks++; if (if_a.pat_count !== 16'd3) $display("FAIL abort_rerun_count: got %0d want 3", if_a.pat_count); else passes++;
    endtask

    task automatic test_start_while_busy;
        start_a(16'd5, 4'h3);
        tick(); tick();
        if_a.num_patterns = 16'd1;
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        checks++; if (if_a.pat_count !== 16'd3) $display("FAIL busy_start_count: got %0d want 3", if_a.pat_count); else passes++;
        checks++; if (if_a.busy !== 1'b1) $display("FAIL busy_start_busy: got %b want 1", if_a.busy); else passes++;
        tick(); tick(); tick();
        checks++; if (if_a.done !== 1'b1) $display("FAIL busy_start_done: got %b want 1", if_a.done); else passes++;
        checks++; if (if_a.pat_count !== 16'd5) $display("FAIL busy_start_final: got %0d want 5", if_a.pat_count); else passes++;
        checks++; if (if_a.signature !== 4'h3) $display("FAIL busy_start_sig: got %h want 3", if_a.signature); else passes++;
        checks++; if (if_a.pass !== 1'b1) $display("FAIL busy_start_pass: got %b want 1", if_a.pass); else passes++;
    endtask

    task automatic test_reset_midrun;
        start_a(16'd10, 4'h0);
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_a.dut_in !== 4'h1) $display("FAIL arst_dut_in: got %h want 1", if_a.dut_in); else passes++;
        checks++; if (if_a.busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", if_a.busy); else passes++;
        checks++; if (if_a.pat_count !== 16'd0) $display("FAIL arst_count: got %0d want 0", if_a.pat_count); else passes++;
        checks++; if (if_a.signature !== 4'h0) $display("FAIL arst_sig: got %h want 0", if_a.signature); else passes++;
        checks++; if (if_a.done !== 1'b0) $display("FAIL arst_done: got %b want 0", if_a.done); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (if_a.busy !== 1'b0) $display("FAIL arst_no_resume_busy: got %b want 0", if_a.busy); else passes++;
        checks++; if (if_a.pat_count !== 16'd0) $display("FAIL arst_no_resume_count: got %0d want 0", if_a.pat_count); else passes++;
        checks++; if (if_a.dut_in !== 4'h1) $display("FAIL arst_no_resume_lfsr: got %h want 1", if_a.dut_in); else passes++;
    endtask

    initial begin
        lfsr_seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                     4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        if_a.start = 1'b0; if_a.abort = 1'b0; if_a.num_patterns = '0; if_a.exp_sig = '0;
        if_b.start = 1'b0; if_b.abort = 1'b0; if_b.num_patterns = '0; if_b.exp_sig = '0;

        test_reset();
        test_lfsr_sequence();
        test_loopback();
        test_zero_patterns();
        test_settle();
        test_abort();
        test_start_while_busy();
        test_reset_midrun();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
